stall_control_block: RTL and testbench



---
 rtl/stall_control_block_if.sv | 19 +
 rtl/stall_control_block.sv | 54 +++++
 tb/tb_stall_control_block.sv | 120 ++++++++++++
 3 files changed

// File: rtl/stall_control_block_if.sv
// Decode-to-stall-control bundle: opcode in, stall requests out.
// The master is the decode side; the slave is the stall generator.
interface stall_control_block_if;
    logic [5:0] op;
    logic       stall;
    logic       stall_pm;

    modport master (
        output op,
        input  stall,
        input  stall_pm
    );

    modport slave (
        input  op,
        output stall,
        output stall_pm
    );
endinterface

// File: rtl/stall_control_block.sv
// Hazard stall generator: halt holds, load gives one bubble, jump two.
// stall_pm is stall delayed one clock to gate program-memory fetch.
module stall_control_block #(
    parameter logic [5:0] OP_HLT = 6'b010001,
    parameter logic [5:0] OP_LD  = 6'b010100,
    parameter logic [5:0] OP_JMP = 6'b011110
) (
    input logic                  clk,
    input logic                  reset,
    stall_control_block_if.slave sc
);

    logic is_hlt;
    logic is_ld;
    logic is_jmp;
    logic stall_c;

    logic ld_q, ld_d;
    logic j1_q, j1_d;
    logic j2_q, j2_d;
    logic pm_q, pm_d;

    always_comb begin
        is_hlt  = (sc.op == OP_HLT);
        is_ld   = (sc.op == OP_LD);
        is_jmp  = (sc.op == OP_JMP);
        // History flops suppress re-trigger while the opcode is held
        stall_c = reset & (is_hlt
                         | (is_ld & ~ld_q)
                         | (is_jmp & ~j2_q));
        ld_d    = is_ld;
        j1_d    = is_jmp;
        j2_d    = j1_q;
        pm_d    = stall_c;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_q <= 1'b0;
            j1_q <= 1'b0;
            j2_q <= 1'b0;
            pm_q <= 1'b0;
        end else begin
            ld_q <= ld_d;
            j1_q <= j1_d;
            j2_q <= j2_d;
            pm_q <= pm_d;
        end
    end

    assign sc.stall    = stall_c;
    assign sc.stall_pm = reset & pm_q;

endmodule

// File: tb/tb_stall_control_block.sv
// Directed bench for stall_control_block with hand-computed waveforms.
// Clock period 10, posedges at 5, 15, 25, ...
module tb_stall_control_block;

    localparam logic [5:0] HLT = 6'b010001;
    localparam logic [5:0] LD  = 6'b010100;
    localparam logic [5:0] JMP = 6'b011110;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    stall_control_block_if sc ();

    stall_control_block dut (
        .clk   (clk),
        .reset (reset),
        .sc    (sc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic obs,
                            input logic exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b expected %b",
                     tag, $time, obs, exp);
        end
    endtask

    task automatic at(input int t);
        if (t > $time) #(t - $time);
    endtask

    task automatic chk2(input string tag, input logic s,
                        input logic p);
        check_eq({tag, ".stall"}, sc.stall, s);
        check_eq({tag, ".stall_pm"}, sc.stall_pm, p);
    endtask

    logic [5:0] others [5];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        others[0] = 6'b000000;
        others[1] = 6'b111111;
        others[2] = 6'b010000;
        others[3] = 6'b010101;
        others[4] = 6'b011111;

        reset = 1'b1;
        sc.op = 6'd0;
        at(2);  reset = 1'b0;
        at(3);  chk2("rst_low", 1'b0, 1'b0);
        at(8);  reset = 1'b1;
        at(10); chk2("rst_rel", 1'b0, 1'b0);

        at(16); sc.op = LD;
        at(17); chk2("ld_a", 1'b1, 1'b0);
        at(27); chk2("ld_b", 1'b0, 1'b1);
        at(36); sc.op = 6'd0;
        at(37); chk2("ld_c", 1'b0, 1'b0);

        at(46); sc.op = JMP;
        at(47); chk2("jmp_a", 1'b1, 1'b0);
        at(57); chk2("jmp_b", 1'b1, 1'b1);
        at(67); chk2("jmp_c", 1'b0, 1'b1);
        at(76); sc.op = 6'd0;
        at(77); chk2("jmp_d", 1'b0, 1'b0);

        at(86);  sc.op = HLT;
        at(87);  chk2("hlt_a", 1'b1, 1'b0);
        at(97);  chk2("hlt_b", 1'b1, 1'b1);
        at(107); chk2("hlt_c", 1'b1, 1'b1);

        at(110); reset = 1'b0;
        at(111); chk2("hlt_rst", 1'b0, 1'b0);
        at(112); reset = 1'b1;
        at(113); chk2("hlt_rel", 1'b1, 1'b0);
        at(117); chk2("hlt_rel2", 1'b1, 1'b1);

        at(118); sc.op = LD;
        at(119); chk2("rearm_a", 1'b1, 1'b1);
        at(127); chk2("rearm_b", 1'b0, 1'b1);
        at(137); chk2("rearm_c", 1'b0, 1'b0);
        at(147); chk2("rearm_d", 1'b0, 1'b0);
        at(148); sc.op = 6'd0;
        at(156); sc.op = LD;
        at(157); chk2("rearm_e", 1'b1, 1'b0);
        at(167); chk2("rearm_f", 1'b0, 1'b1);
        at(168); sc.op = 6'd0;

        // Jump cut short by a load: jump burst ends, load burst starts
        at(176); sc.op = JMP;
        at(177); chk2("cut_a", 1'b1, 1'b0);
        at(186); sc.op = LD;
        at(187); chk2("cut_b", 1'b1, 1'b1);
        at(197); chk2("cut_c", 1'b0, 1'b1);
        at(198); sc.op = 6'd0;
        at(207); chk2("cut_d", 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            at(216 + 10 * i);
            sc.op = others[i];
            at(217 + 10 * i);
            chk2($sformatf("other%0d", i), 1'b0, 1'b0);
        end
        at(270);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
